// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle FSM and the RV32 datapath.
// master = controller side, slave = datapath side.
interface multicycle_controller_if #(
    parameter int INSTRET_W = 32
);
    logic [6:0]           op_i;
    logic                 zero_i;
    logic                 mem_ready_i;
    logic                 mem_req_o;
    logic                 mem_we_o;
    logic                 adr_src_o;
    logic                 ir_write_o;
    logic                 pc_write_o;
    logic                 reg_write_o;
    logic [1:0]           alu_src_a_o;
    logic [1:0]           alu_src_b_o;
    logic [1:0]           alu_op_o;
    logic [1:0]           result_src_o;
    logic [2:0]           imm_src_o;
    logic                 instr_done_o;
    logic                 illegal_o;
    logic [INSTRET_W-1:0] instret_o;

    modport master (
        input  op_i, zero_i, mem_ready_i,
        output mem_req_o, mem_we_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o,
               alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o, imm_src_o,
               instr_done_o, illegal_o, instret_o
    );

    modport slave (
        output op_i, zero_i, mem_ready_i,
        input  mem_req_o, mem_we_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o,
               alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o, imm_src_o,
               instr_done_o, illegal_o, instret_o
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for a shared-memory multicycle RV32 datapath, with a
// retired-instruction counter. Outputs decode from state (and ready/zero/op).
module multicycle_controller #(
    parameter int INSTRET_W = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    multicycle_controller_if.master bus
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_JALR, S_JALR_LINK,
        S_LUI, S_TRAP
    } state_t;

    state_t               r_state;
    logic [INSTRET_W-1:0] r_instret;

    logic       w_mem_req, w_mem_we, w_adr_src, w_ir_write, w_pc_write, w_reg_write;
    logic [1:0] w_src_a, w_src_b, w_alu_op, w_result_src;
    logic [2:0] w_imm_src;
    logic       w_done, w_illegal;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:     if (bus.mem_ready_i) r_state <= S_DECODE;
                S_DECODE: begin
                    case (bus.op_i)
                        OP_LOAD, OP_STORE: r_state <= S_MEMADR;
                        OP_R:              r_state <= S_EXECR;
                        OP_I:              r_state <= S_EXECI;
                        OP_BEQ:            r_state <= S_BEQ;
                        OP_JAL:            r_state <= S_JAL;
                        OP_JALR:           r_state <= S_JALR;
                        OP_LUI:            r_state <= S_LUI;
                        default:           r_state <= S_TRAP;
                    endcase
                end
                S_MEMADR:    r_state <= (bus.op_i == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:   if (bus.mem_ready_i) r_state <= S_MEMWB;
                S_MEMWB:     r_state <= S_FETCH;
                S_MEMWRITE:  if (bus.mem_ready_i) r_state <= S_FETCH;
                S_EXECR,
                S_EXECI,
                S_LUI:       r_state <= S_ALUWB;
                S_ALUWB:     r_state <= S_FETCH;
                S_BEQ:       r_state <= S_FETCH;
                S_JAL:       r_state <= S_ALUWB;
                S_JALR:      r_state <= S_JALR_LINK;
                S_JALR_LINK: r_state <= S_ALUWB;
                S_TRAP:      r_state <= S_TRAP;
                default:     r_state <= S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)       r_instret <= '0;
        else if (w_done) r_instret <= r_instret + INSTRET_W'(1);
    end

    // Immediate format depends only on the opcode, independent of state.
    always_comb begin
        w_imm_src = 3'b000;
        case (bus.op_i)
            OP_STORE: w_imm_src = 3'b001;
            OP_BEQ:   w_imm_src = 3'b010;
            OP_JAL:   w_imm_src = 3'b011;
            OP_LUI:   w_imm_src = 3'b100;
            default:  w_imm_src = 3'b000;
        endcase
    end

    always_comb begin
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_adr_src    = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_src_a      = 2'b00;
        w_src_b      = 2'b00;
        w_alu_op     = 2'b00;
        w_result_src = 2'b00;
        w_done       = 1'b0;
        w_illegal    = 1'b0;
        if (rst_i) begin
            // Reset overrides whatever state is held: FETCH selects, no strobes.
            w_src_b      = 2'b10;
            w_result_src = 2'b10;
        end else begin
            case (r_state)
                S_FETCH: begin
                    w_mem_req    = 1'b1;
                    w_src_b      = 2'b10;
                    w_result_src = 2'b10;
                    w_ir_write   = bus.mem_ready_i;
                    w_pc_write   = bus.mem_ready_i;
                end
                S_DECODE: begin
                    w_src_a = 2'b01;
                    w_src_b = 2'b01;
                end
                S_MEMADR, S_JALR: begin
                    w_src_a = 2'b10;
                    w_src_b = 2'b01;
                end
                S_MEMREAD: begin
                    w_mem_req = 1'b1;
                    w_adr_src = 1'b1;
                end
                S_MEMWB: begin
                    w_result_src = 2'b01;
                    w_reg_write  = 1'b1;
                    w_done       = 1'b1;
                end
                S_MEMWRITE: begin
                    w_mem_req = 1'b1;
                    w_mem_we  = 1'b1;
                    w_adr_src = 1'b1;
                    w_done    = bus.mem_ready_i;
                end
                S_EXECR: begin
                    w_src_a  = 2'b10;
                    w_alu_op = 2'b10;
                end
                S_EXECI: begin
                    w_src_a  = 2'b10;
                    w_src_b  = 2'b01;
                    w_alu_op = 2'b10;
                end
                S_LUI: begin
                    w_src_b  = 2'b01;
                    w_alu_op = 2'b11;
                end
                S_ALUWB: begin
                    w_reg_write = 1'b1;
                    w_done      = 1'b1;
                end
                S_BEQ: begin
                    w_src_a    = 2'b10;
                    w_alu_op   = 2'b01;
                    w_pc_write = bus.zero_i;
                    w_done     = 1'b1;
                end
                // PC takes the target held in ALUOut while the ALU forms OldPC+4.
                S_JAL, S_JALR_LINK: begin
                    w_src_a    = 2'b01;
                    w_src_b    = 2'b10;
                    w_pc_write = 1'b1;
                end
                S_TRAP:  w_illegal = 1'b1;
                default: w_illegal = 1'b0;
            endcase
        end
    end

    assign bus.mem_req_o    = w_mem_req;
    assign bus.mem_we_o     = w_mem_we;
    assign bus.adr_src_o    = w_adr_src;
    assign bus.ir_write_o   = w_ir_write;
    assign bus.pc_write_o   = w_pc_write;
    assign bus.reg_write_o  = w_reg_write;
    assign bus.alu_src_a_o  = w_src_a;
    assign bus.alu_src_b_o  = w_src_b;
    assign bus.alu_op_o     = w_alu_op;
    assign bus.result_src_o = w_result_src;
    assign bus.imm_src_o    = w_imm_src;
    assign bus.instr_done_o = w_done;
    assign bus.illegal_o    = w_illegal;
    assign bus.instret_o    = r_instret;
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: a 32-bit and a 4-bit counter instance share
// stimulus; per-cycle expected control words go through a scoreboard queue.
module tb_multicycle_controller;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_BAD  = 7'b1111111;

    localparam int T_FETCH = 0,  T_DECODE = 1, T_MEMADR = 2, T_MEMREAD = 3, T_MEMWB = 4;
    localparam int T_MEMWRITE = 5, T_EXECR = 6, T_EXECI = 7, T_ALUWB = 8, T_BEQ = 9;
    localparam int T_JAL = 10, T_JALR = 11, T_JALR_LINK = 12, T_LUI = 13, T_TRAP = 14, T_RST = 15;

    typedef struct packed {
        logic req, we, adr, irw, pcw, rw;
        logic [1:0] a, b, aop, res;
        logic done, ill;
        logic [2:0] imm;
    } ctl_t;
    typedef struct packed { ctl_t c; logic [31:0] n; } exp_t;
    typedef struct { int st; logic [6:0] op; logic z; logic r; logic rs; } step_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [6:0] op;
    logic       zero, rdy;

    multicycle_controller_if #(.INSTRET_W(32)) b32 ();
    multicycle_controller_if #(.INSTRET_W(4))  b4 ();
    assign b32.op_i = op;  assign b32.zero_i = zero;  assign b32.mem_ready_i = rdy;
    assign b4.op_i  = op;  assign b4.zero_i  = zero;  assign b4.mem_ready_i  = rdy;

    multicycle_controller #(.INSTRET_W(32)) u32 (.clk_i(clk), .rst_i(rst), .bus(b32.master));
    multicycle_controller #(.INSTRET_W(4))  u4  (.clk_i(clk), .rst_i(rst), .bus(b4.master));

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] model_n = 32'd0;

    // Expected outputs straight from the state table of the control spec.
    function automatic ctl_t ctl_of(int st, logic [6:0] o, logic z, logic r);
        ctl_t c;
        c = '0;
        case (o)
            OP_SW:   c.imm = 3'b001;
            OP_BEQ:  c.imm = 3'b010;
            OP_JAL:  c.imm = 3'b011;
            OP_LUI:  c.imm = 3'b100;
            default: c.imm = 3'b000;
        endcase
        case (st)
            T_RST:       begin c.b = 2'b10; c.res = 2'b10; end
            T_FETCH:     begin c.req = 1; c.b = 2'b10; c.res = 2'b10; c.irw = r; c.pcw = r; end
            T_DECODE:    begin c.a = 2'b01; c.b = 2'b01; end
            T_MEMADR:    begin c.a = 2'b10; c.b = 2'b01; end
            T_MEMREAD:   begin c.req = 1; c.adr = 1; end
            T_MEMWB:     begin c.res = 2'b01; c.rw = 1; c.done = 1; end
            T_MEMWRITE:  begin c.req = 1; c.we = 1; c.adr = 1; c.done = r; end
            T_EXECR:     begin c.a = 2'b10; c.aop = 2'b10; end
            T_EXECI:     begin c.a = 2'b10; c.b = 2'b01; c.aop = 2'b10; end
            T_LUI:       begin c.b = 2'b01; c.aop = 2'b11; end
            T_ALUWB:     begin c.rw = 1; c.done = 1; end
            T_BEQ:       begin c.a = 2'b10; c.aop = 2'b01; c.pcw = z; c.done = 1; end
            T_JAL:       begin c.a = 2'b01; c.b = 2'b10; c.pcw = 1; end
            T_JALR:      begin c.a = 2'b10; c.b = 2'b01; end
            T_JALR_LINK: begin c.a = 2'b01; c.b = 2'b10; c.pcw = 1; end
            T_TRAP:      c.ill = 1;
            default:     c = '0;
        endcase
        return c;
    endfunction

    function automatic ctl_t observe();
        ctl_t c;
        c.req = b32.mem_req_o;   c.we = b32.mem_we_o;       c.adr = b32.adr_src_o;
        c.irw = b32.ir_write_o;  c.pcw = b32.pc_write_o;    c.rw = b32.reg_write_o;
        c.a = b32.alu_src_a_o;   c.b = b32.alu_src_b_o;     c.aop = b32.alu_op_o;
        c.res = b32.result_src_o; c.done = b32.instr_done_o; c.ill = b32.illegal_o;
        c.imm = b32.imm_src_o;
        return c;
    endfunction

    function automatic step_t stp(int st, logic [6:0] o, logic z = 1'b0, logic r = 1'b1, logic rs = 1'b0);
        step_t s;
        s.st = st; s.op = o; s.z = z; s.r = r; s.rs = rs;
        return s;
    endfunction

    // Drive one cycle of inputs and push what the model expects for it.
    // Inputs a state must ignore are randomized.
    task automatic apply(step_t s);
        ctl_t c;
        rst = s.rs;
        op  = s.op;
        zero = (s.st == T_BEQ) ? s.z : 1'($urandom_range(1, 0));
        rdy  = (s.st == T_FETCH || s.st == T_MEMREAD || s.st == T_MEMWRITE) ? s.r
                                                                              : 1'($urandom_range(1, 0));
        c = ctl_of(s.st, s.op, s.z, s.r);
        sb.push_back('{c: c, n: model_n});
        if (s.rs)        model_n = 32'd0;
        else if (c.done) model_n = model_n + 32'd1;
    endtask

    task automatic test_reset();
        step_t q[$];
        exp_t  e;
        ctl_t  g;
        q.push_back(stp(T_RST, OP_LW, 1'b0, 1'b1, 1'b1));
        q.push_back(stp(T_RST, OP_SW, 1'b0, 1'b1, 1'b1));
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            e = sb.pop_front();
            g = observe();
            total++; if (g !== e.c) begin bad++; $display("FAIL reset ctl step %0d got %h want %h", i, g, e.c); end
            total++; if (b32.instret_o !== e.n) begin bad++; $display("FAIL reset instret32 got %0d want %0d", b32.instret_o, e.n); end
            total++; if (b4.instret_o !== e.n[3:0]) begin bad++; $display("FAIL reset instret4 got %0d want %0d", b4.instret_o, e.n[3:0]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem();
        step_t q[$];
        exp_t  e;
        ctl_t  g;
        q.push_back(stp(T_FETCH, OP_LW));   q.push_back(stp(T_DECODE, OP_LW));
        q.push_back(stp(T_MEMADR, OP_LW));  q.push_back(stp(T_MEMREAD, OP_LW));
        q.push_back(stp(T_MEMWB, OP_LW));
        q.push_back(stp(T_FETCH, OP_SW));   q.push_back(stp(T_DECODE, OP_SW));
        q.push_back(stp(T_MEMADR, OP_SW));
        for (int k = 0; k < 3; k++) q.push_back(stp(T_MEMWRITE, OP_SW, 1'b0, 1'b0));
        q.push_back(stp(T_MEMWRITE, OP_SW));
        q.push_back(stp(T_FETCH, OP_LW, 1'b0, 1'b0)); q.push_back(stp(T_FETCH, OP_LW));
        q.push_back(stp(T_DECODE, OP_LW));  q.push_back(stp(T_MEMADR, OP_LW));
        q.push_back(stp(T_MEMREAD, OP_LW, 1'b0, 1'b0)); q.push_back(stp(T_MEMREAD, OP_LW));
        q.push_back(stp(T_MEMWB, OP_LW));
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            e = sb.pop_front();
            g = observe();
            total++; if (g !== e.c) begin bad++; $display("FAIL mem ctl step %0d got %h want %h", i, g, e.c); end
            total++; if (b32.instret_o !== e.n) begin bad++; $display("FAIL mem instret32 step %0d got %0d want %0d", i, b32.instret_o, e.n); end
            total++; if (b4.instret_o !== e.n[3:0]) begin bad++; $display("FAIL mem instret4 step %0d got %0d want %0d", i, b4.instret_o, e.n[3:0]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_jump();
        step_t q[$];
        exp_t  e;
        ctl_t  g;
        q.push_back(stp(T_FETCH, OP_BEQ)); q.push_back(stp(T_DECODE, OP_BEQ));
        q.push_back(stp(T_BEQ, OP_BEQ, 1'b1));
        q.push_back(stp(T_FETCH, OP_BEQ)); q.push_back(stp(T_DECODE, OP_BEQ));
        q.push_back(stp(T_BEQ, OP_BEQ, 1'b0));
        q.push_back(stp(T_FETCH, OP_JALR)); q.push_back(stp(T_DECODE, OP_JALR));
        q.push_back(stp(T_JALR, OP_JALR));  q.push_back(stp(T_JALR_LINK, OP_JALR));
        q.push_back(stp(T_ALUWB, OP_JALR));
        q.push_back(stp(T_FETCH, OP_JAL)); q.push_back(stp(T_DECODE, OP_JAL));
        q.push_back(stp(T_JAL, OP_JAL));   q.push_back(stp(T_ALUWB, OP_JAL));
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            e = sb.pop_front();
            g = observe();
            total++; if (g !== e.c) begin bad++; $display("FAIL branch ctl step %0d got %h want %h", i, g, e.c); end
            total++; if (b32.instret_o !== e.n) begin bad++; $display("FAIL branch instret32 step %0d got %0d want %0d", i, b32.instret_o, e.n); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu();
        step_t q[$];
        exp_t  e;
        ctl_t  g;
        q.push_back(stp(T_FETCH, OP_R, 1'b0, 1'b0)); q.push_back(stp(T_FETCH, OP_R));
        q.push_back(stp(T_DECODE, OP_R)); q.push_back(stp(T_EXECR, OP_R)); q.push_back(stp(T_ALUWB, OP_R));
        q.push_back(stp(T_FETCH, OP_I));  q.push_back(stp(T_DECODE, OP_I));
        q.push_back(stp(T_EXECI, OP_I));  q.push_back(stp(T_ALUWB, OP_I));
        q.push_back(stp(T_FETCH, OP_LUI)); q.push_back(stp(T_DECODE, OP_LUI));
        q.push_back(stp(T_LUI, OP_LUI));   q.push_back(stp(T_ALUWB, OP_LUI));
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            e = sb.pop_front();
            g = observe();
            total++; if (g !== e.c) begin bad++; $display("FAIL alu ctl step %0d got %h want %h", i, g, e.c); end
            total++; if (b32.instret_o !== e.n) begin bad++; $display("FAIL alu instret32 step %0d got %0d want %0d", i, b32.instret_o, e.n); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_trap();
        step_t q[$];
        exp_t  e;
        ctl_t  g;
        q.push_back(stp(T_FETCH, OP_BAD)); q.push_back(stp(T_DECODE, OP_BAD));
        for (int k = 0; k < 10; k++) q.push_back(stp(T_TRAP, OP_BAD));
        q.push_back(stp(T_RST, OP_BAD, 1'b0, 1'b1, 1'b1));
        q.push_back(stp(T_FETCH, OP_LUI)); q.push_back(stp(T_DECODE, OP_LUI));
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            e = sb.pop_front();
            g = observe();
            total++; if (g !== e.c) begin bad++; $display("FAIL trap ctl step %0d got %h want %h", i, g, e.c); end
            total++; if (b32.instret_o !== e.n) begin bad++; $display("FAIL trap instret32 step %0d got %0d want %0d", i, b32.instret_o, e.n); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        step_t q[$];
        exp_t  e;
        ctl_t  g;
        q.push_back(stp(T_RST, OP_I, 1'b0, 1'b1, 1'b1));
        for (int k = 0; k < 16; k++) begin
            q.push_back(stp(T_FETCH, OP_I)); q.push_back(stp(T_DECODE, OP_I));
            q.push_back(stp(T_EXECI, OP_I)); q.push_back(stp(T_ALUWB, OP_I));
        end
        q.push_back(stp(T_FETCH, OP_I, 1'b0, 1'b0));
        q.push_back(stp(T_RST, OP_I, 1'b0, 1'b0, 1'b1));
        q.push_back(stp(T_FETCH, OP_I, 1'b0, 1'b0));
        q.push_back(stp(T_FETCH, OP_I));
        q.push_back(stp(T_DECODE, OP_I));
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            e = sb.pop_front();
            g = observe();
            total++; if (g !== e.c) begin bad++; $display("FAIL b2b ctl step %0d got %h want %h", i, g, e.c); end
            total++; if (b32.instret_o !== e.n) begin bad++; $display("FAIL b2b instret32 step %0d got %0d want %0d", i, b32.instret_o, e.n); end
            total++; if (b4.instret_o !== e.n[3:0]) begin bad++; $display("FAIL b2b instret4 step %0d got %0d want %0d", i, b4.instret_o, e.n[3:0]); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst  = 1'b1;
        op   = 7'd0;
        zero = 1'b0;
        rdy  = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_mem();
        test_branch_jump();
        test_alu();
        test_trap();
        test_back_to_back();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard leftover got %0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style control FSM that sequences a shared-memory, multicycle RV32 datapath: one ALU, one unified instruction/data memory port, and an instruction register. It replaces the per-instruction combinational main decode with a state machine. The FSM steps each instruction through fetch, decode, execute, memory and writeback, and waits on a memory ready handshake. It sits between the instruction register opcode field and every datapath mux and write-enable, and keeps a retired-instruction counter.

## Interface
- INSTRET_W, 32, width of the retired-instruction counter
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous reset, active-high
- op_i  in  7  opcode field of the instruction register (valid from DECODE onward)
- zero_i  in  1  ALU zero flag, combinational from current ALU inputs
- mem_ready_i  in  1  memory accepts/completes the current request this cycle
- mem_req_o  out  1  memory request strobe
- mem_we_o  out  1  request is a write (qualified by mem_req_o)
- adr_src_o  out  1  memory address select: 0 = PC, 1 = ALUOut register
- ir_write_o  out  1  load instruction register and OldPC register
- pc_write_o  out  1  load PC from result bus
- reg_write_o  out  1  register file write enable
- alu_src_a_o  out  2  00 = PC, 01 = OldPC, 10 = rs1 register
- alu_src_b_o  out  2  00 = rs2 register, 01 = immediate, 10 = constant 4
- alu_op_o  out  2  00 = add, 01 = subtract/compare, 10 = funct-decoded, 11 = pass immediate (lui)
- result_src_o  out  2  00 = ALUOut register, 01 = memory read data, 10 = ALU result direct
- imm_src_o  out  3  000 = I (load, op-imm, jalr), 001 = S, 010 = B, 011 = J, 100 = U; 000 for other opcodes
- instr_done_o  out  1  one-cycle pulse in the final cycle of each instruction
- illegal_o  out  1  high while in TRAP
- instret_o  out  INSTRET_W  count of retired instructions

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, JALR, JALR_LINK, LUI, TRAP.
- Unlisted selects are 00/0 and unlisted strobes are 0. imm_src_o is decoded from op_i in every state.
- FETCH: mem_req=1, adr_src=0, a=00, b=10, alu_op=00, result_src=10.
  - When mem_ready_i=1: ir_write=1 and pc_write=1 (PC ← PC+4), then go to DECODE.
  - Otherwise hold FETCH with all strobes low except mem_req.
- DECODE: a=01, b=01, alu_op=00 (ALUOut ← OldPC+imm). Next state by op_i:
  - 0000011 / 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - anything else → TRAP
- MEMADR: a=10, b=01, alu_op=00. Go to MEMREAD if op_i=0000011, else MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. Hold until mem_ready_i, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_done=1, then FETCH.
- MEMWRITE: mem_req=1, mem_we=1, adr_src=1. Hold until mem_ready_i; on that cycle instr_done=1, then FETCH.
- EXECR: a=10, b=00, alu_op=10, then ALUWB.
- EXECI: a=10, b=01, alu_op=10, then ALUWB.
- LUI: b=01, alu_op=11, then ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1, then FETCH.
- BEQ: a=10, b=00, alu_op=01, result_src=00, pc_write=zero_i, instr_done=1, then FETCH.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1 (PC ← target in ALUOut), then ALUWB (rd ← OldPC+4).
- JALR: a=10, b=01, alu_op=00 (ALUOut ← rs1+imm), then JALR_LINK.
- JALR_LINK: same outputs as JAL, then ALUWB.
- TRAP: illegal_o=1, all strobes 0. Exit only by reset.
- instret_o increments by 1 on every cycle with instr_done_o=1 and wraps modulo 2^INSTRET_W.

## Timing
- Reset: while rst_i=1, the state is forced to FETCH and instret_o to 0.
  - In any cycle with rst_i=1, mem_req_o, mem_we_o, ir_write_o, pc_write_o, reg_write_o, instr_done_o and illegal_o are 0.
  - Selects take their FETCH values.
  - The first fetch request appears in the first cycle after rst_i falls.
- Reset mid-instruction (including a pending memory wait or TRAP) aborts with no further strobes.
- Cycle counts with zero-wait memory:
  - lw: 5
  - sw: 4
  - R-type, I-type, lui: 4
  - beq: 3
  - jal: 4
  - jalr: 5
- Each memory wait cycle adds 1. mem_req_o stays high and the outputs stay stable until mem_ready_i.
- mem_ready_i is ignored outside FETCH, MEMREAD and MEMWRITE.
- All outputs are combinational from state, op_i, zero_i and mem_ready_i. No output depends on an input in a state that does not use it.

## Test plan
- Reset, then lw (op 0000011) with mem_ready_i always 1 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. reg_write_o=1 with result_src_o=01 in cycle 5, instr_done_o pulses once, instret_o=1.
- sw with mem_ready_i low for 3 cycles in MEMWRITE → mem_req_o=1 and mem_we_o=1 held for 4 cycles. Done in the 4th of those cycles, no reg_write_o.
- beq twice, zero_i=1 then zero_i=0 → pc_write_o=1 in BEQ only for the first, 3 cycles each, instret_o=2.
- jalr → pc_write_o in JALR_LINK with a=01, b=10, then ALUWB reg_write_o; 5 cycles total.
- Opcode 1111111 → TRAP, illegal_o=1 and all strobes 0 for 10 cycles. rst_i=1 then returns to FETCH, illegal_o=0, instret_o=0.
- INSTRET_W=4, 16 back-to-back addi → instret_o wraps 15 → 0. Assert rst_i during a FETCH wait → mem_req_o=0 that cycle.
